rmii_tx: RTL and testbench
==========================

# rmii_tx

Ethernet transmitter with an RMII PHY interface, clocked by the 50 MHz REF_CLK. It pops frame bytes (header+body) from a first-word-fall-through TX FIFO whose end of frame is marked by an EOD flag. It emits preamble, SFD and body dibit-serially on TXD[1:0]/TX_EN, optionally appends FCS, and enforces the inter-frame gap. It is the transmit-side counterpart of the RMII receive path and reports gray-coded monitor counters for cross-domain sampling.

## Interface
- IFG_BYTES, 12: inter-frame gap in byte times; TX_EN is held low for 4*IFG_BYTES cycles after each frame.
- PREAMBLE_BYTES, 7: number of 0x55 bytes sent before the SFD.
- REF_CLK  in  1  RMII reference clock; all logic runs on its rising edge.
- arst_n  in  1  asynchronous, active-low reset.
- fifo_empty  in  1  FIFO empty (FWFT: fifo_dout/fifo_EOD_out are valid whenever low).
- fifo_dout  in  8  head byte.
- fifo_EOD_out  in  1  head byte is the last byte of its frame.
- frame_avail  in  1  at least one complete frame (with EOD) is resident in the FIFO.
- fifo_rden  out  1  single-cycle pop strobe.
- TX_EN  out  1  RMII transmit enable (registered).
- TXD0, TXD1  out  1 each  RMII dibit (registered).
- succ_tx_count_gray  out  16  frames completed, gray-coded.
- underrun_count_gray  out  16  frames aborted by underrun, gray-coded.

## Operation
- States: S_IDLE, S_PREAMBLE, S_BODY, S_FCS, S_IFG. Any illegal encoding goes to S_IFG.
- A 2-bit dibit counter cnt runs in every transmitting state. A byte lasts 4 cycles; dibit k = byte[2k+1:2k] (LSB first, TXD0 = even bit).
- S_IDLE: TX_EN=0, TXD=00. If frame_avail=1, go to S_PREAMBLE with cnt=0.
- S_PREAMBLE: send PREAMBLE_BYTES×0x55, then 0xD5 (4*(PREAMBLE_BYTES+1) cycles). In the last SFD dibit cycle, go to S_BODY.
- S_BODY: on cnt==0, latch fifo_dout into the shift register, pulse fifo_rden, and capture EOD. On cnt==3 of a byte with EOD=1, go to S_FCS (FCS enabled) or S_IFG.
- Underrun: fifo_empty=1 at a cnt==0 byte fetch in S_BODY. Then: no pop, TX_EN falls next edge, underrun counter +1, go to S_IFG. The remainder of the frame stays in the FIFO, and upstream owns recovery.
- S_FCS: 16 dibits of the complemented CRC, LSB first, then S_IFG; succ counter +1 on entry to S_IFG from a normal end.
- S_IFG: TX_EN=0 for 4*IFG_BYTES cycles, then S_IDLE. frame_avail is ignored during IFG.
- No padding to 60 bytes; the producer supplies minimum-length frames.
- Counters: 16-bit binary, wrap 0xFFFF→0x0000, converted combinationally via the shared bin2gray helper.
- Reset mid-frame: all outputs and counters are zero immediately; the state goes to S_IDLE. The partial frame's FIFO bytes are not flushed.

## Timing
- Reset values: TX_EN=0, TXD0=TXD1=0, fifo_rden=0, both gray counters 0.
- Start latency: frame_avail sampled high in S_IDLE at edge N, so the first preamble dibit (TXD1:TXD0=01) and TX_EN=1 appear after edge N+1.
- First body dibit appears 4*(PREAMBLE_BYTES+1) cycles after the first preamble dibit; TX_EN stays continuously high until the final dibit.
- fifo_rden is high exactly one cycle per body byte, in the cycle the byte is latched; the next head is needed 4 cycles later.
- Frame duration with TX_EN high: 4*(PREAMBLE_BYTES+1+L[+4]) cycles for L body bytes.
- Back-to-back frames: consecutive TX_EN high periods are separated by exactly 4*IFG_BYTES low cycles.

## Configuration
- RMII_TX_FCS_EN defined: the CRC-32 is computed over body dibits (reflected poly 0xEDB88320, init 0xFFFFFFFF, output complemented) and appended in S_FCS.
- RMII_TX_FCS_EN undefined: no S_FCS state and no CRC logic. The FIFO frame must already contain the FCS, and EOD leads directly to S_IFG.

## Structure
- Package rmii_pkg: state encodings, PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, CRC_INIT, CRC_POLY_REFL, default IFG.
- Sub-module rmii_tx_crc32: dibit-serial CRC-32 with init/enable/2-bit data ports and a 32-bit state output. It is instantiated only under RMII_TX_FCS_EN.

## Test plan
- Reset: hold arst_n low with frame_avail=1 → TX_EN=0, TXD=00, counters 0; the first dibit appears 2 edges after release.
- Single frame with body 0x31..0x39 ("123456789"), FCS enabled → 32 preamble/SFD dibits ending 01,01,01,11. The body follows, then FCS bytes 26 39 F4 CB. TX_EN is high for 84 cycles and succ_tx_count_gray=0x0001.
- Same frame with FCS disabled and FIFO holding 13 bytes (body+FCS) → identical wire bits; 13 fifo_rden pulses.
- Two queued 64-byte frames → exactly 48 TX_EN-low cycles between them; succ count 2 (gray 0x0003).
- fifo_empty forced high at the 10th body fetch → TX_EN drops the next edge, underrun_count_gray=0x0001, and 48 idle cycles follow before frame_avail is sampled again.
- Preload the succ counter near 0xFFFF via 65536 short frames (or a forced state) → wraps to gray 0x0000. An async reset mid-body drops TX_EN within the same cycle.

Source files
------------

// File: rtl/rmii_pkg.sv
// Shared definitions for the RMII transmit path: FSM state encodings,
// preamble/SFD bytes, CRC-32 constants, default timing parameters and the
// binary-to-gray helper used by the monitor counters.
package rmii_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_BODY     = 3'd2,
    S_FCS      = 3'd3,
    S_IFG      = 3'd4
  } tx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

  localparam int IFG_BYTES_DFLT      = 12;
  localparam int PREAMBLE_BYTES_DFLT = 7;

  function automatic logic [15:0] bin2gray(input logic [15:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/rmii_tx_crc32.sv
// Dibit-serial reflected CRC-32 (Ethernet FCS). Each enabled cycle folds in
// two bits, i_data[0] first, matching the LSB-first order on the wire.
// Only compiled when RMII_TX_FCS_EN is defined; without it the frame in the
// FIFO already carries its FCS and no CRC logic exists.
`ifdef RMII_TX_FCS_EN
module rmii_tx_crc32
  import rmii_pkg::*;
(
  input  logic        REF_CLK,
  input  logic        arst_n,
  input  logic        i_init,
  input  logic        i_en,
  input  logic [1:0]  i_data,
  output logic [31:0] o_crc
);

  logic [31:0] r_crc;
  logic [31:0] w_crc_nxt;

  // Two LFSR steps per cycle, one per dibit bit.
  always_comb begin
    w_crc_nxt = r_crc;
    for (int i = 0; i < 2; i++) begin
      w_crc_nxt = (w_crc_nxt >> 1) ^ ((w_crc_nxt[0] ^ i_data[i]) ? CRC_POLY_REFL : 32'h0);
    end
  end

  // CRC state: seeded while no body is being sent, advanced per body dibit.
  always_ff @(posedge REF_CLK or negedge arst_n) begin
    if (!arst_n) begin
      r_crc <= CRC_INIT;
    end else if (i_init) begin
      r_crc <= CRC_INIT;
    end else if (i_en) begin
      r_crc <= w_crc_nxt;
    end
  end

  assign o_crc = r_crc;

endmodule
`endif

// File: rtl/rmii_tx.sv
// RMII transmitter: pulls frame bytes from a FWFT FIFO, sends preamble/SFD
// and body as dibits on TXD1:TXD0 with TX_EN, optionally appends the FCS
// (macro RMII_TX_FCS_EN), and holds the inter-frame gap.
//
// state       | meaning
// ------------+--------------------------------------------------------
// S_IDLE      | line quiet, waiting for a complete frame in the FIFO
// S_PREAMBLE  | PREAMBLE_BYTES x 0x55 then 0xD5
// S_BODY      | one FIFO byte per 4 cycles, popped on dibit 0
// S_FCS       | 16 dibits of the complemented CRC (FCS build only)
// S_IFG       | line quiet for the gap; frame_avail ignored
//
// Outputs are registered from the current state, so the wire lags the FSM
// by one cycle. S_IFG lasts one cycle less than the gap because S_IDLE
// always adds one quiet cycle before the next preamble.
module rmii_tx
  import rmii_pkg::*;
#(
  parameter int IFG_BYTES      = IFG_BYTES_DFLT,
  parameter int PREAMBLE_BYTES = PREAMBLE_BYTES_DFLT
) (
  input  logic        REF_CLK,
  input  logic        arst_n,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_dout,
  input  logic        fifo_EOD_out,
  input  logic        frame_avail,
  output logic        fifo_rden,
  output logic        TX_EN,
  output logic        TXD0,
  output logic        TXD1,
  output logic [15:0] succ_tx_count_gray,
  output logic [15:0] underrun_count_gray
);

  localparam logic [15:0] TMR_PRE = 16'(PREAMBLE_BYTES);
  localparam logic [15:0] TMR_IFG = 16'(4 * IFG_BYTES - 2);
  localparam logic [15:0] TMR_FCS = 16'd3;

  tx_state_e   r_state;
  tx_state_e   w_state_nxt;
  logic [1:0]  r_cnt;
  logic [1:0]  w_cnt_nxt;
  logic [15:0] r_tmr;
  logic [15:0] w_tmr_nxt;
  logic [7:0]  r_shift;
  logic        r_eod;
  logic        r_tx_en;
  logic [1:0]  r_txd;
  logic [15:0] r_succ;
  logic [15:0] r_underrun;

  logic        w_tx_en_nxt;
  logic [1:0]  w_txd_nxt;
  logic        w_rden;
  logic        w_succ_inc;
  logic        w_under_inc;
  logic [7:0]  w_pre_byte;
  logic [7:0]  w_body_byte;

`ifdef RMII_TX_FCS_EN
  logic [31:0] w_crc;
  logic        w_crc_init;
  logic        w_crc_en;
  logic [4:0]  w_fcs_idx;

  // r_tmr counts FCS bytes down from 3, so ~r_tmr is the byte index.
  assign w_fcs_idx  = {~r_tmr[1:0], r_cnt, 1'b0};
  assign w_crc_init = (r_state == S_IDLE) || (r_state == S_PREAMBLE);
  assign w_crc_en   = (r_state == S_BODY) && w_tx_en_nxt;

  rmii_tx_crc32 u_crc (
    .REF_CLK (REF_CLK),
    .arst_n  (arst_n),
    .i_init  (w_crc_init),
    .i_en    (w_crc_en),
    .i_data  (w_txd_nxt),
    .o_crc   (w_crc)
  );
`endif

  assign w_pre_byte  = (r_tmr == 16'd0) ? SFD_BYTE : PREAMBLE_BYTE;
  assign w_body_byte = (r_cnt == 2'd0) ? fifo_dout : r_shift;

  // Next state, timer, next wire value and pop/count strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = 2'(r_cnt + 2'd1);
    w_tmr_nxt   = r_tmr;
    w_tx_en_nxt = 1'b0;
    w_txd_nxt   = 2'b00;
    w_rden      = 1'b0;
    w_succ_inc  = 1'b0;
    w_under_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = 2'd0;
        if (frame_avail) begin
          w_state_nxt = S_PREAMBLE;
          w_tmr_nxt   = TMR_PRE;
        end
      end
      S_PREAMBLE: begin
        w_tx_en_nxt = 1'b1;
        w_txd_nxt   = w_pre_byte[{r_cnt, 1'b0} +: 2];
        if (r_cnt == 2'd3) begin
          if (r_tmr == 16'd0) begin
            w_state_nxt = S_BODY;
          end else begin
            w_tmr_nxt = r_tmr - 16'd1;
          end
        end
      end
      S_BODY: begin
        if ((r_cnt == 2'd0) && fifo_empty) begin
          w_under_inc = 1'b1;
          w_state_nxt = S_IFG;
          w_tmr_nxt   = TMR_IFG;
          w_cnt_nxt   = 2'd0;
        end else begin
          w_tx_en_nxt = 1'b1;
          w_txd_nxt   = w_body_byte[{r_cnt, 1'b0} +: 2];
          w_rden      = (r_cnt == 2'd0);
          if ((r_cnt == 2'd3) && r_eod) begin
`ifdef RMII_TX_FCS_EN
            w_state_nxt = S_FCS;
            w_tmr_nxt   = TMR_FCS;
`else
            w_state_nxt = S_IFG;
            w_tmr_nxt   = TMR_IFG;
            w_succ_inc  = 1'b1;
`endif
          end
        end
      end
`ifdef RMII_TX_FCS_EN
      S_FCS: begin
        w_tx_en_nxt = 1'b1;
        w_txd_nxt   = ~w_crc[w_fcs_idx +: 2];
        if (r_cnt == 2'd3) begin
          if (r_tmr == 16'd0) begin
            w_state_nxt = S_IFG;
            w_tmr_nxt   = TMR_IFG;
            w_succ_inc  = 1'b1;
          end else begin
            w_tmr_nxt = r_tmr - 16'd1;
          end
        end
      end
`endif
      S_IFG: begin
        w_cnt_nxt = 2'd0;
        if (r_tmr == 16'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_tmr_nxt = r_tmr - 16'd1;
        end
      end
      default: begin
        w_state_nxt = S_IFG;
        w_tmr_nxt   = TMR_IFG;
        w_cnt_nxt   = 2'd0;
      end
    endcase
  end

  // FSM state, dibit counter and shared down-counter.
  always_ff @(posedge REF_CLK or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
      r_tmr   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tmr   <= w_tmr_nxt;
    end
  end

  // Body byte and its end-of-frame flag, captured on the pop.
  always_ff @(posedge REF_CLK or negedge arst_n) begin
    if (!arst_n) begin
      r_shift <= 8'h00;
      r_eod   <= 1'b0;
    end else if (w_rden) begin
      r_shift <= fifo_dout;
      r_eod   <= fifo_EOD_out;
    end
  end

  // Registered RMII outputs.
  always_ff @(posedge REF_CLK or negedge arst_n) begin
    if (!arst_n) begin
      r_tx_en <= 1'b0;
      r_txd   <= 2'b00;
    end else begin
      r_tx_en <= w_tx_en_nxt;
      r_txd   <= w_txd_nxt;
    end
  end

  // Monitor counters, free-running with natural 16-bit wrap.
  always_ff @(posedge REF_CLK or negedge arst_n) begin
    if (!arst_n) begin
      r_succ     <= 16'd0;
      r_underrun <= 16'd0;
    end else begin
      if (w_succ_inc) begin
        r_succ <= r_succ + 16'd1;
      end
      if (w_under_inc) begin
        r_underrun <= r_underrun + 16'd1;
      end
    end
  end

  assign fifo_rden           = w_rden;
  assign TX_EN               = r_tx_en;
  assign TXD0                = r_txd[0];
  assign TXD1                = r_txd[1];
  assign succ_tx_count_gray  = bin2gray(r_succ);
  assign underrun_count_gray = bin2gray(r_underrun);

endmodule

// File: tb/tb_rmii_tx.sv
// Directed bench for rmii_tx: reset behaviour, the "123456789" frame, gap
// between back-to-back frames, underrun, async reset mid-body and counter
// wrap. A small FWFT FIFO model feeds the DUT; a negedge monitor records
// wire dibits, pop strobes and TX_EN run lengths.
module tb_rmii_tx;

`ifdef RMII_TX_FCS_EN
  localparam int F1_LEN      = 9;
  localparam int FCS_DIBITS  = 16;
`else
  localparam int F1_LEN      = 13;
  localparam int FCS_DIBITS  = 0;
`endif

  logic        REF_CLK = 1'b0;
  logic        arst_n = 1'b0;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic        fifo_EOD_out;
  logic        frame_avail = 1'b0;
  logic        fifo_rden;
  logic        TX_EN;
  logic        TXD0;
  logic        TXD1;
  logic [15:0] succ_g;
  logic [15:0] und_g;

  logic [7:0]  mem_d [0:1023];
  logic        mem_e [0:1023];
  logic [9:0]  wr_ptr = '0;
  logic [9:0]  rd_ptr = '0;
  logic        force_empty = 1'b0;
  logic        tb_flush = 1'b0;

  logic [1:0]  cap [0:4095];
  int          ncap = 0;
  int          n_rden = 0;
  int          low_run = 0;
  int          high_run = 0;
  int          last_low = 0;
  int          last_high = 0;
  logic        prev_en = 1'b0;

  logic [1:0]  exp_d [0:127];
  int          nexp = 0;
  logic [7:0]  f1 [0:12] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                             8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};

  int checks = 0;
  int failures = 0;

  rmii_tx dut (
    .REF_CLK             (REF_CLK),
    .arst_n              (arst_n),
    .fifo_empty          (fifo_empty),
    .fifo_dout           (fifo_dout),
    .fifo_EOD_out        (fifo_EOD_out),
    .frame_avail         (frame_avail),
    .fifo_rden           (fifo_rden),
    .TX_EN               (TX_EN),
    .TXD0                (TXD0),
    .TXD1                (TXD1),
    .succ_tx_count_gray  (succ_g),
    .underrun_count_gray (und_g)
  );

  initial forever #10 REF_CLK = ~REF_CLK;

  assign fifo_dout    = mem_d[rd_ptr];
  assign fifo_EOD_out = mem_e[rd_ptr];
  assign fifo_empty   = (rd_ptr == wr_ptr) || force_empty;

  always @(posedge REF_CLK) begin
    if (tb_flush) rd_ptr <= wr_ptr;
    else if (fifo_rden) rd_ptr <= rd_ptr + 10'd1;
  end

  always @(negedge REF_CLK) begin
    if (fifo_rden) n_rden = n_rden + 1;
    if (TX_EN) begin
      if (!prev_en) begin
        last_low = low_run;
        high_run = 0;
      end
      cap[ncap] = {TXD1, TXD0};
      ncap = ncap + 1;
      high_run = high_run + 1;
      low_run = 0;
    end else begin
      if (prev_en) last_high = high_run;
      low_run = low_run + 1;
    end
    prev_en = TX_EN;
  end

  task automatic tick();
    @(posedge REF_CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_en(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (TX_EN !== lvl && n < budget) begin
      tick();
      n++;
    end
    check(tag, {31'd0, TX_EN}, {31'd0, lvl});
  endtask

  task automatic push(input logic [7:0] b, input logic eod);
    mem_d[wr_ptr] = b;
    mem_e[wr_ptr] = eod;
    wr_ptr = wr_ptr + 10'd1;
  endtask

  task automatic push_f1();
    for (int i = 0; i < F1_LEN; i++) push(f1[i], i == F1_LEN - 1);
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int k = 0; k < 4; k++) exp_d[nexp + k] = b[2*k +: 2];
    nexp = nexp + 4;
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    tb_flush = 1'b1;
    tick();
    tick();
    tb_flush = 1'b0;
    arst_n = 1'b1;
  endtask

  initial begin
    int s;
    int r0;
    int nmis;
    int n;

    // Expected wire for the "123456789" frame: preamble, SFD, body, FCS.
    for (int i = 0; i < 7; i++) add_byte(8'h55);
    add_byte(8'hD5);
    for (int i = 0; i < 13; i++) add_byte(f1[i]);

    // Reset held with a frame ready.
    push_f1();
    frame_avail = 1'b1;
    tick();
    tick();
    check("rst_tx_en", {31'd0, TX_EN}, 32'd0);
    check("rst_txd", {30'd0, TXD1, TXD0}, 32'd0);
    check("rst_rden", {31'd0, fifo_rden}, 32'd0);
    check("rst_succ", {16'd0, succ_g}, 32'd0);
    check("rst_und", {16'd0, und_g}, 32'd0);

    // Start latency: quiet after first edge, first preamble dibit after second.
    #4 arst_n = 1'b1;
    tick();
    check("start_edge1_en", {31'd0, TX_EN}, 32'd0);
    tick();
    check("start_edge2_en", {31'd0, TX_EN}, 32'd1);
    check("start_edge2_txd", {30'd0, TXD1, TXD0}, 32'd1);
    s = ncap;
    frame_avail = 1'b0;
    wait_en(1'b0, 200, "f1_end");
    tick();
    check("f1_dibits", ncap - s, 32'd84);
    check("f1_high_run", last_high, 32'd84);
    check("f1_sfd_last", {30'd0, cap[s + 31]}, 32'd3);
    check("f1_body_first", {30'd0, cap[s + 32]}, 32'd1);
    nmis = 0;
    for (int i = 0; i < 84; i++) if (cap[s + i] !== exp_d[i]) nmis++;
    check("f1_wire_mismatches", nmis, 32'd0);
    check("f1_rden", n_rden, F1_LEN);
    check("f1_succ", {16'd0, succ_g}, 32'h0001);
    check("f1_und", {16'd0, und_g}, 32'h0000);

    // Two queued 64-byte frames back to back.
    do_reset();
    for (int i = 0; i < 128; i++) push(8'(i), (i == 63) || (i == 127));
    r0 = n_rden;
    frame_avail = 1'b1;
    wait_en(1'b1, 10, "b2b_start1");
    wait_en(1'b0, 400, "b2b_end1");
    tick();
    check("b2b_high1", last_high, 32'(4 * (8 + 64) + FCS_DIBITS));
    wait_en(1'b1, 100, "b2b_start2");
    tick();
    frame_avail = 1'b0;
    check("b2b_gap", last_low, 32'd48);
    wait_en(1'b0, 400, "b2b_end2");
    tick();
    check("b2b_high2", last_high, 32'(4 * (8 + 64) + FCS_DIBITS));
    check("b2b_rden", n_rden - r0, 32'd128);
    check("b2b_succ", {16'd0, succ_g}, 32'h0003);

    // Underrun at the 10th body fetch of a 20-byte frame.
    do_reset();
    for (int i = 0; i < 20; i++) push(8'(8'hA0 + i), i == 19);
    r0 = n_rden;
    frame_avail = 1'b1;
    wait_en(1'b1, 10, "ur_start");
    n = 0;
    while ((n_rden - r0) < 9 && n < 200) begin
      tick();
      n++;
    end
    check("ur_pop9", n_rden - r0, 32'd9);
    force_empty = 1'b1;
    wait_en(1'b0, 20, "ur_drop");
    force_empty = 1'b0;
    tick();
    check("ur_high_run", last_high, 32'd68);
    check("ur_und", {16'd0, und_g}, 32'h0001);
    check("ur_succ", {16'd0, succ_g}, 32'h0000);
    check("ur_rden", n_rden - r0, 32'd9);
    // 48 idle cycles before frame_avail is sampled, plus one start-latency cycle.
    wait_en(1'b1, 100, "ur_restart");
    frame_avail = 1'b0;
    tick();
    check("ur_gap", last_low, 32'd49);
    wait_en(1'b0, 200, "ur_rest_end");
    tick();
    check("ur_rest_high", last_high, 32'(4 * (8 + 11) + FCS_DIBITS));
    check("ur_rest_rden", n_rden - r0, 32'd20);
    check("ur_rest_succ", {16'd0, succ_g}, 32'h0001);

    // Async reset in the middle of a body.
    for (int i = 0; i < 20; i++) push(8'(8'hC0 + i), i == 19);
    frame_avail = 1'b1;
    wait_en(1'b1, 100, "mid_start");
    frame_avail = 1'b0;
    repeat (40) tick();
    check("mid_in_body", {31'd0, TX_EN}, 32'd1);
    #4 arst_n = 1'b0;
    #1;
    check("mid_rst_en", {31'd0, TX_EN}, 32'd0);
    check("mid_rst_txd", {30'd0, TXD1, TXD0}, 32'd0);
    check("mid_rst_succ", {16'd0, succ_g}, 32'd0);
    check("mid_rst_und", {16'd0, und_g}, 32'd0);
    tick();
    do_reset();

    // Success counter wrap from 0xFFFF.
    force dut.r_succ = 16'hFFFF;
    tick();
    release dut.r_succ;
    check("wrap_pre", {16'd0, succ_g}, 32'h8000);
    push_f1();
    frame_avail = 1'b1;
    wait_en(1'b1, 10, "wrap_start");
    frame_avail = 1'b0;
    wait_en(1'b0, 200, "wrap_end");
    tick();
    check("wrap_post", {16'd0, succ_g}, 32'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
